// File: rtl/cpu_pkg.sv
// Shared CPU pipeline definitions: payload width and
// skid-stage occupancy encoding {skidValid, mainValid}.
package cpu_pkg;

    localparam int DATA_WIDTH = 64;

    // 2'b10 is deliberately absent: skid never holds without main.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        FULL1 = 2'b01,
        FULL2 = 2'b11
    } stageState_e;

endpackage

// File: rtl/register_en.sv
// WIDTH-bit register with enable, one enable flop per bit.
// Ports: clk, reset (sync, active-low), en, d -> q.
module register_en #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    for (genvar i = 0; i < WIDTH; i++) begin : gBit
        logic bitQ;

        always_ff @(posedge clk) begin
            if (!reset) begin
                bitQ <= 1'b0;
            end else if (en) begin
                bitQ <= d[i];
            end
        end

        assign q[i] = bitQ;
    end

endmodule

// File: rtl/pipe_skid_stage.sv
// Pipeline stage register with valid/ready handshake and a
// two-entry skid buffer; in_ready comes straight from a flop.
// Ports: clk, reset (sync, active-low), flush,
//   in_valid/in_ready/in_data (upstream),
//   out_valid/out_ready/out_data (downstream).
module pipe_skid_stage
    import cpu_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    stageState_e      state;
    stageState_e      nextState;
    logic [1:0]       stateBits;
    logic             accept;
    logic             drain;
    logic             mainEn;
    logic             skidEn;
    logic             mainFromSkid;
    logic [WIDTH-1:0] mainD;
    logic [WIDTH-1:0] mainData;
    logic [WIDTH-1:0] skidData;

    assign stateBits = state;
    assign out_valid = stateBits[0];
    assign in_ready  = ~stateBits[1];
    assign out_data  = mainData;

    assign accept = in_valid & in_ready;
    assign drain  = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= EMPTY;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState    = state;
        mainEn       = 1'b0;
        skidEn       = 1'b0;
        mainFromSkid = 1'b0;
        unique case (state)
            EMPTY: begin
                if (accept) begin
                    mainEn    = 1'b1;
                    nextState = FULL1;
                end
            end
            FULL1: begin
                if (accept && drain) begin
                    mainEn = 1'b1;
                end else if (accept) begin
                    skidEn    = 1'b1;
                    nextState = FULL2;
                end else if (drain) begin
                    nextState = EMPTY;
                end
            end
            FULL2: begin
                if (drain) begin
                    mainEn       = 1'b1;
                    mainFromSkid = 1'b1;
                    nextState    = FULL1;
                end
            end
            default: begin
                nextState = EMPTY;
            end
        endcase
        // Squash drops valids and any same-cycle accept;
        // data registers keep their contents.
        if (flush) begin
            nextState = EMPTY;
            mainEn    = 1'b0;
            skidEn    = 1'b0;
        end
    end

    assign mainD = mainFromSkid ? skidData : in_data;

    register_en #(.WIDTH(WIDTH)) uMain (
        .clk   (clk),
        .reset (reset),
        .en    (mainEn),
        .d     (mainD),
        .q     (mainData)
    );

    register_en #(.WIDTH(WIDTH)) uSkid (
        .clk   (clk),
        .reset (reset),
        .en    (skidEn),
        .d     (in_data),
        .q     (skidData)
    );

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Scoreboard bench for pipe_skid_stage.
// Queue model of the two-entry stage, checked every cycle.
module tb_pipe_skid_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;

    int checks = 0;
    int errors = 0;

    logic [63:0] sb[$];

    always #5 clk = ~clk;

    pipe_skid_stage #(.WIDTH(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Skid-only occupancy would show as in_ready=0 with out_valid=0.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            chk("legal_state", 64'(!(!in_ready && !out_valid)), 64'd1);
        end
    end

    // Drive one cycle, check outputs against the model, advance.
    task automatic step(input logic iv, input logic [63:0] id,
                        input logic ordy, input logic fl);
        logic mReady;
        logic mValid;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        mReady = (sb.size() < 2);
        mValid = (sb.size() > 0);
        chk("in_ready", 64'(in_ready), 64'(mReady));
        chk("out_valid", 64'(out_valid), 64'(mValid));
        if (mValid) begin
            chk("out_data", out_data, sb[0]);
        end
        @(posedge clk);
        #1;
        if (fl) begin
            sb.delete();
        end else begin
            if (mValid && ordy) begin
                void'(sb.pop_front());
            end
            if (iv && mReady) begin
                sb.push_back(id);
            end
        end
    endtask

    initial begin
        reset     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'hAA;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_data", out_data, 64'd0);

        reset = 1'b1;
        step(1'b1, 64'hAA, 1'b0, 1'b0);
        step(1'b0, 64'h0, 1'b1, 1'b0);
        step(1'b0, 64'h0, 1'b1, 1'b0);

        for (int i = 1; i <= 4; i++) begin
            step(1'b1, 64'(i), 1'b1, 1'b0);
        end
        step(1'b0, 64'h0, 1'b1, 1'b0);
        step(1'b0, 64'h0, 1'b1, 1'b0);

        step(1'b1, 64'd10, 1'b0, 1'b0);
        step(1'b1, 64'd11, 1'b0, 1'b0);
        step(1'b1, 64'd12, 1'b0, 1'b0);
        chk("fill_in_ready", 64'(in_ready), 64'd0);
        chk("fill_hold", out_data, 64'd10);
        step(1'b1, 64'd12, 1'b1, 1'b0);
        step(1'b1, 64'd12, 1'b1, 1'b0);
        step(1'b0, 64'h0, 1'b1, 1'b0);
        step(1'b0, 64'h0, 1'b1, 1'b0);
        chk("release_empty", 64'(sb.size()), 64'd0);

        step(1'b1, 64'd20, 1'b0, 1'b0);
        step(1'b1, 64'd21, 1'b0, 1'b0);
        step(1'b1, 64'd99, 1'b0, 1'b1);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        step(1'b0, 64'h0, 1'b1, 1'b0);
        step(1'b0, 64'h0, 1'b1, 1'b0);

        step(1'b1, 64'd5, 1'b0, 1'b0);
        step(1'b1, 64'd6, 1'b1, 1'b0);
        chk("sim_out_data", out_data, 64'd6);
        chk("sim_out_valid", 64'(out_valid), 64'd1);
        chk("sim_skid_empty", 64'(in_ready), 64'd1);
        step(1'b0, 64'h0, 1'b1, 1'b0);

        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)),
                 {32'($urandom), 32'($urandom)},
                 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 29) == 0));
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 64'h0, 1'b1, 1'b0);
        end
        chk("final_empty", 64'(out_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
